// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package cache_pkg;

    // Controller states: serving hits, filling a missed line, writing through a store.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } cache_state_e;

    // Access size encoding carried on cpu_addrmode / mem_addrmode.
    localparam logic ADDRMODE_WORD = 1'b0;
    localparam logic ADDRMODE_BYTE = 1'b1;

    // Number of index bits for a given number of one-word lines.
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over after the 2-bit byte offset and the index.
    function automatic int tag_bits(input int width, input int sets);
        return width - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag, valid and data storage for the data cache: asynchronous read port,
// one write port with per-byte-lane enables. Only the valid bits are reset.
module cache_line_array #(
    parameter int WIDTH = 32,
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [WIDTH-1:0]     rd_data,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic                 wr_en,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_tag_en,
    input  logic [TAG_W-1:0]     wr_tag
);

    localparam int LANES = WIDTH / 8;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [WIDTH-1:0] data_q [SETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_tag_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag storage, written together with the valid bit on a fill.
    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    // Data storage with byte-lane write enables (full word on fill, lanes on store hit).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return data combinationally; misses fill from memory, stores always
// write through. Optional hit/miss counters are built with DATA_CACHE_STATS_EN.
module data_cache
    import cache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_addrmode,
    input  logic [WIDTH-1:0]  cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addrmode,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
`ifdef DATA_CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output cache_state_e      state_dbg
);

    localparam int IDX_W = index_bits(SETS);
    localparam int TAG_W = tag_bits(WIDTH, SETS);
    localparam int LANES = WIDTH / 8;

    cache_state_e state_q, state_d;

    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [WIDTH-1:0] rd_data;
    logic [7:0]       rd_byte;
    logic             line_hit;
    logic             load_hit;
    logic             fill_start;
    logic [LANES-1:0] store_be;
    logic [WIDTH-1:0] store_data;
    logic             arr_wr_en;
    logic [LANES-1:0] arr_wr_be;
    logic [WIDTH-1:0] arr_wr_data;
    logic             arr_tag_en;

    assign offset = cpu_addr[1:0];
    assign index  = cpu_addr[2 +: IDX_W];
    assign tag    = cpu_addr[WIDTH-1 -: TAG_W];

    cache_line_array #(
        .WIDTH (WIDTH),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (index),
        .wr_en     (arr_wr_en),
        .wr_be     (arr_wr_be),
        .wr_data   (arr_wr_data),
        .wr_tag_en (arr_tag_en),
        .wr_tag    (tag)
    );

    // The line at the current index holds the current address (load or store).
    assign line_hit   = rd_valid && (rd_tag == tag);
    assign load_hit   = !rst && (state_q == ST_IDLE) && cpu_req && !cpu_we && line_hit;
    assign fill_start = !rst && (state_q == ST_IDLE) && cpu_req && !cpu_we && !line_hit;

    // Load data: full word, or the addressed byte zero-extended.
    assign rd_byte   = rd_data[{offset, 3'b000} +: 8];
    assign cpu_rdata = (cpu_addrmode == ADDRMODE_BYTE) ? {{(WIDTH-8){1'b0}}, rd_byte} : rd_data;
    assign state_dbg = state_q;

    // Store-hit merge: byte stores replicate bits [7:0] and enable only the addressed lane.
    always_comb begin
        store_be   = '1;
        store_data = cpu_wdata;
        if (cpu_addrmode == ADDRMODE_BYTE) begin
            store_be         = '0;
            store_be[offset] = 1'b1;
            store_data       = {LANES{cpu_wdata[7:0]}};
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall, memory request and line-array writes. Reset forces
    // the memory request low and suppresses any line update, so a late
    // mem_ready after an aborted access lands in IDLE and is ignored.
    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addrmode = ADDRMODE_WORD;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        arr_wr_en    = 1'b0;
        arr_wr_be    = '0;
        arr_wr_data  = mem_rdata;
        arr_tag_en   = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req && cpu_we) begin
                        state_d = ST_WRITE;
                        stall   = 1'b1;
                    end else if (cpu_req && !line_hit) begin
                        state_d = ST_FILL;
                        stall   = 1'b1;
                    end
                end
                ST_FILL: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {cpu_addr[WIDTH-1:2], 2'b00};
                    if (mem_ready) begin
                        arr_wr_en   = 1'b1;
                        arr_wr_be   = '1;
                        arr_wr_data = mem_rdata;
                        arr_tag_en  = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addrmode = cpu_addrmode;
                    stall        = !mem_ready;
                    if (mem_ready) begin
                        state_d = ST_IDLE;
                        if (line_hit) begin
                            arr_wr_en   = 1'b1;
                            arr_wr_be   = store_be;
                            arr_wr_data = store_data;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss counters: hits on load hits, misses on entry to FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (fill_start && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    // Counter-only qualifiers have no consumer in this build.
    logic unused_stats;
    assign unused_stats = load_hit ^ fill_start;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache (WIDTH=32, SETS=16). Also covers the
// DATA_CACHE_STATS_EN counters when that macro is defined.
module tb_data_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_addrmode;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we, mem_addrmode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    cache_state_e state_dbg;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks   = 0;
    int failures = 0;
    int mem_writes = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] exp_q[$];

    data_cache #(.WIDTH(32), .SETS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addrmode (cpu_addrmode),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addrmode (mem_addrmode),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
`ifdef DATA_CACHE_STATS_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock: 10 ns period, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load: hit path checks same-cycle data; miss path serves the fill after
    // 'lat' request cycles, then checks the follow-up hit and the stall count.
    task automatic cpu_load(input string tag, input logic [31:0] addr, input logic mode,
                            input bit exp_hit, input int lat, input logic [31:0] mem_word,
                            input logic [31:0] exp_data, input int exp_stalls);
        int stalls;
        stalls = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addrmode = mode; cpu_addr = addr;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #4;
        if (exp_hit) begin
            check({tag, "_stall"}, stall, 1'b0);
            check({tag, "_rdata"}, cpu_rdata, exp_data);
            check({tag, "_memreq"}, mem_req, 1'b0);
            exp_hits++;
        end else begin
            if (stall) stalls++;
            check({tag, "_miss_memreq"}, mem_req, 1'b0);
            exp_misses++;
            tick();
            for (int c = 1; c <= lat; c++) begin
                mem_ready = (c == lat);
                mem_rdata = mem_word;
                #4;
                if (stall) stalls++;
                check({tag, "_fill_req"}, {mem_req, mem_we}, 2'b10);
                check({tag, "_fill_addr"}, mem_addr, {addr[31:2], 2'b00});
                tick();
            end
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            #4;
            check({tag, "_stall_cycles"}, stalls, exp_stalls);
            check({tag, "_after_stall"}, stall, 1'b0);
            check({tag, "_after_rdata"}, cpu_rdata, exp_data);
            exp_hits++;
        end
        tick();
        cpu_req = 1'b0;
    endtask

    // Store: one write-through request completed after 'lat' cycles.
    task automatic cpu_store(input string tag, input logic [31:0] addr, input logic mode,
                             input logic [31:0] wdata, input int lat);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addrmode = mode; cpu_addr = addr; cpu_wdata = wdata;
        mem_ready = 1'b0;
        exp_q.push_back(addr);
        #4;
        check({tag, "_detect_stall"}, stall, 1'b1);
        tick();
        for (int c = 1; c <= lat; c++) begin
            mem_ready = (c == lat);
            #4;
            check({tag, "_req_we_mode"}, {mem_req, mem_we, mem_addrmode}, {2'b11, mode});
            check({tag, "_wdata"}, mem_wdata, wdata);
            check({tag, "_stall"}, stall, (c == lat) ? 1'b0 : 1'b1);
            if (mem_req && mem_we && mem_ready) begin
                mem_writes++;
                if (exp_q.size() > 0) check({tag, "_addr"}, mem_addr, exp_q.pop_front());
            end
            tick();
        end
        mem_ready = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        int writes_before;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addrmode = ADDRMODE_WORD;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        tick();
        tick();
        #4;
        check("reset_state", state_dbg, ST_IDLE);
        check("reset_mem_req_we", {mem_req, mem_we}, 2'b00);
        check("reset_stall", stall, 1'b0);
        tick();
        rst = 1'b0;

        // lw miss with 2-cycle memory, then repeat lw and lbu hits
        cpu_load("lw1004_miss", 32'h1004, ADDRMODE_WORD, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 3);
        cpu_load("lw1004_hit", 32'h1004, ADDRMODE_WORD, 1, 0, 32'h0, 32'hDEADBEEF, 0);
        cpu_load("lbu1006", 32'h1006, ADDRMODE_BYTE, 1, 0, 32'h0, 32'h000000AD, 0);
        cpu_load("lbu1004", 32'h1004, ADDRMODE_BYTE, 1, 0, 32'h0, 32'h000000EF, 0);

        // sb into the cached line updates only lane 1
        cpu_store("sb1005", 32'h1005, ADDRMODE_BYTE, 32'hFFFFFF77, 1);
        cpu_load("lw1004_sb", 32'h1004, ADDRMODE_WORD, 1, 0, 32'h0, 32'hDEAD77EF, 0);
        cpu_load("lbu1007", 32'h1007, ADDRMODE_BYTE, 1, 0, 32'h0, 32'h000000DE, 0);

        // sw hit updates the whole word
        cpu_store("sw1004", 32'h1004, ADDRMODE_WORD, 32'hA5A5C3C3, 2);
        cpu_load("lw1004_sw", 32'h1004, ADDRMODE_WORD, 1, 0, 32'h0, 32'hA5A5C3C3, 0);

        // sw to uncached address: one memory write, no allocate
        writes_before = mem_writes;
        cpu_store("sw2000", 32'h2000, ADDRMODE_WORD, 32'h12345678, 3);
        check("sw2000_write_count", mem_writes - writes_before, 1);
        cpu_load("lw2000_miss", 32'h2000, ADDRMODE_WORD, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2);

        // conflict eviction: 0x1044 shares index 1 with 0x1004
        cpu_load("lw1044_miss", 32'h1044, ADDRMODE_WORD, 0, 1, 32'h44444444, 32'h44444444, 2);
        cpu_load("lw1004_evicted", 32'h1004, ADDRMODE_WORD, 0, 1, 32'h11111111, 32'h11111111, 2);

`ifdef DATA_CACHE_STATS_EN
        #4;
        check("stats_hits", hit_count, exp_hits);
        check("stats_misses", miss_count, exp_misses);
        tick();
`endif

        // reset mid-FILL, memory answers one cycle later
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addrmode = ADDRMODE_WORD; cpu_addr = 32'h3008;
        tick();
        #4;
        check("abort_fill_state", state_dbg, ST_FILL);
        check("abort_fill_req", mem_req, 1'b1);
        tick();
        rst = 1'b1;
        #4;
        check("abort_rst_memreq", {mem_req, mem_we}, 2'b00);
        tick();
        rst = 1'b0; cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAADBAAD;
        exp_hits = 0; exp_misses = 0;
        #4;
        check("abort_idle_state", state_dbg, ST_IDLE);
        check("abort_late_ready_memreq", mem_req, 1'b0);
        check("abort_late_ready_stall", stall, 1'b0);
        tick();
        mem_ready = 1'b0;
        cpu_load("lw3008_after_abort", 32'h3008, ADDRMODE_WORD, 0, 1, 32'h0BADF00D, 32'h0BADF00D, 2);
        cpu_load("lw1004_after_rst", 32'h1004, ADDRMODE_WORD, 0, 1, 32'h22222222, 32'h22222222, 2);

`ifdef DATA_CACHE_STATS_EN
        #4;
        check("stats_hits_after_rst", hit_count, exp_hits);
        check("stats_misses_after_rst", miss_count, exp_misses);
        tick();
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
